// File: rtl/fifo_flush_pkg.sv
// Shared types and constants for the nibble-FIFO drain reader.
// Holds the FSM state encoding, nibble/word geometry and the packed word type.
// No logic; imported by fifo_flush_reader and nibble_packer.
package fifo_flush_pkg;

    localparam int NIB_W     = 4;                  // FIFO entry width
    localparam int WORD_NIBS = 8;                  // nibbles per output word
    localparam int WORD_W    = NIB_W * WORD_NIBS;  // 32-bit output word
    localparam int CNT_W     = 6;                  // drained-entry counter width
    localparam int SLOT_W    = $clog2(WORD_NIBS) + 1;  // nib_cnt plus headroom for nib_cnt+pop_q

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        TAIL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/nibble_packer.sv
// Nibble packer: assembles captured nibbles into a word and holds it on a valid/ready output.
// Latency: word appears on out_data the cycle after its last nibble is captured.
// Backpressure: out_data/out_valid held stable while out_valid && !out_ready; caller must not
// complete a word while the output register is occupied (slot_free tells it when it may).
// Ports: cap/cap_data capture a nibble into slot nib_cnt; tail_load emits the partial word
// (upper nibbles already zero); tail_drop discards it; word_loading flags a full word moving
// to the output register this cycle; slot_free = output register can take a word this cycle.
module nibble_packer
    import fifo_flush_pkg::*;
(
    input  logic              rclock,
    input  logic              reset,
    input  logic              cap,
    input  nib_t              cap_data,
    input  logic              tail_load,
    input  logic              tail_drop,
    input  logic              out_ready,
    output word_t             out_data,
    output logic              out_valid,
    output logic [SLOT_W-1:0] nib_cnt,
    output logic              word_loading,
    output logic              slot_free
);

    word_t pack_q;
    word_t pack_next;

    // Pack register with the incoming nibble dropped into its slot.
    always_comb begin
        pack_next = pack_q;
        for (int k = 0; k < WORD_NIBS; k++) begin
            if (nib_cnt == SLOT_W'(k)) begin
                pack_next[k*NIB_W +: NIB_W] = cap_data;
            end
        end
    end

    assign word_loading = cap && (nib_cnt == SLOT_W'(WORD_NIBS - 1));
    assign slot_free    = !out_valid || out_ready;

    // pack_q is cleared whenever its contents leave, so a partial word emitted
    // later always has its unused upper nibbles at zero.
    always_ff @(posedge rclock) begin
        if (reset) begin
            pack_q    <= '0;
            nib_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (word_loading) begin
                out_data  <= pack_next;
                out_valid <= 1'b1;
                pack_q    <= '0;
                nib_cnt   <= '0;
            end else if (cap) begin
                pack_q    <= pack_next;
                nib_cnt   <= nib_cnt + SLOT_W'(1);
            end else if (tail_load) begin
                out_data  <= pack_q;
                out_valid <= 1'b1;
                pack_q    <= '0;
                nib_cnt   <= '0;
            end else if (tail_drop) begin
                pack_q    <= '0;
                nib_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/fifo_flush_reader.sv
// Read-side drain controller: on drain_start_i pops the nibble FIFO until empty, packs 8 nibbles
// per 32-bit word (first popped in [3:0]) and presents words on out_valid_o/out_ready_i.
// Latency: FIFO data lands 1 cycle after fifo_pop_o; word valid 1 cycle after its last capture.
// Backpressure: pops stall before the word-completing nibble while the output slot is busy.
// Ports: rclock/reset (sync, active high); drain_start_i; fifo_empty_i/fifo_rd_data_i/fifo_pop_o
// to the FIFO; out_data_o/out_valid_o/out_ready_i downstream; busy_o, done_o, drained_cnt_o status.
// Build option FIFO_FLUSH_READER_PAD_EN: emit a trailing partial word zero-padded; otherwise drop it.
module fifo_flush_reader
    import fifo_flush_pkg::*;
(
    input  logic             rclock,
    input  logic             reset,
    input  logic             drain_start_i,
    input  logic             fifo_empty_i,
    input  logic [NIB_W-1:0] fifo_rd_data_i,
    output logic             fifo_pop_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] drained_cnt_o
);

    state_t            state;
    logic              pop_q;
    logic [SLOT_W-1:0] nib_cnt;
    logic [SLOT_W-1:0] fill;
    logic              word_loading;
    logic              slot_free;
    logic              tail_load;
    logic              tail_drop;

    nibble_packer u_packer (
        .rclock       (rclock),
        .reset        (reset),
        .cap          (pop_q),
        .cap_data     (fifo_rd_data_i),
        .tail_load    (tail_load),
        .tail_drop    (tail_drop),
        .out_ready    (out_ready_i),
        .out_data     (out_data_o),
        .out_valid    (out_valid_o),
        .nib_cnt      (nib_cnt),
        .word_loading (word_loading),
        .slot_free    (slot_free)
    );

    // Nibbles captured or in flight once this cycle's capture lands.
    assign fill = nib_cnt + SLOT_W'(pop_q);

    // The pop that would complete a word is only issued when the output
    // register is guaranteed free next cycle.
    assign fifo_pop_o = (state == DRAIN) && !fifo_empty_i &&
                        ((fill < SLOT_W'(WORD_NIBS - 1)) || (slot_free && !word_loading));

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE) && slot_free;

`ifdef FIFO_FLUSH_READER_PAD_EN
    assign tail_load = (state == TAIL) && slot_free;
    assign tail_drop = 1'b0;
`else
    assign tail_load = 1'b0;
    assign tail_drop = (state == TAIL);
`endif

    always_ff @(posedge rclock) begin
        if (reset) begin
            state         <= IDLE;
            pop_q         <= 1'b0;
            drained_cnt_o <= '0;
        end else begin
            pop_q <= fifo_pop_o;
            if (fifo_pop_o && (drained_cnt_o != {CNT_W{1'b1}})) begin
                drained_cnt_o <= drained_cnt_o + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    // No pops happen in IDLE, so the clear cannot race the increment.
                    if (drain_start_i) begin
                        drained_cnt_o <= '0;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty is sampled live, so late writes keep the drain going.
                    if (fifo_empty_i && !pop_q) begin
                        state <= (nib_cnt != '0) ? TAIL : DONE;
                    end
                end
                TAIL: begin
                    if (tail_load || tail_drop) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (slot_free) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_flush_reader.sv
// Self-checking bench for fifo_flush_reader: table vectors, timing corner sequences and
// randomized drains against a list-based packing model.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_fifo_flush_reader;
    import fifo_flush_pkg::*;

    logic        rclock = 1'b0;
    logic        reset = 1'b1;
    logic        drain_start_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [3:0]  fifo_rd_data_i = 4'h0;
    logic        out_ready_i = 1'b1;
    logic        fifo_pop_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        busy_o;
    logic        done_o;
    logic [5:0]  drained_cnt_o;

    always #5 rclock = ~rclock;

    fifo_flush_reader dut (
        .rclock         (rclock),
        .reset          (reset),
        .drain_start_i  (drain_start_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_pop_o     (fifo_pop_o),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .drained_cnt_o  (drained_cnt_o)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  fq[$];      // FIFO contents
    logic [3:0]  src[$];     // nibbles loaded for the current drain
    logic [31:0] exp_w[$];   // expected words
    logic [31:0] got[$];     // words accepted downstream
    int          pop_cnt = 0;
    int          done_cnt = 0;
    bit          seen_valid = 1'b0;
    bit          hold_chk = 1'b0;
    logic [31:0] hold_dat = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Registered-read FIFO: data and empty both update on the edge after a pop or write.
    always @(posedge rclock) begin
        if (fifo_pop_o && fq.size() > 0) begin
            fifo_rd_data_i <= fq.pop_front();
        end
        fifo_empty_i <= (fq.size() == 0);
    end

    // Monitor: handshakes, pops, done pulses and output stability under stall.
    always @(negedge rclock) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (fifo_pop_o) begin
                pop_cnt++;
                check("pop_when_empty", 32'(fifo_empty_i), 32'd0);
            end
            if (hold_chk) begin
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_data", out_data_o, hold_dat);
            end
            if (out_valid_o) seen_valid = 1'b1;
            if (out_valid_o && out_ready_i) got.push_back(out_data_o);
            if (done_o) done_cnt++;
            hold_chk = out_valid_o && !out_ready_i;
            hold_dat = out_data_o;
        end
    end

    // Reference: cut the popped list into groups of eight, first nibble lowest.
    function automatic void build_expected();
        exp_w.delete();
        for (int i = 0; i < src.size(); i += 8) begin
            logic [31:0] w;
            int k;
            w = 32'h0;
            for (k = 0; k < 8 && (i + k) < src.size(); k++) begin
                w[4*k +: 4] = src[i+k];
            end
            if (k == 8) exp_w.push_back(w);
`ifdef FIFO_FLUSH_READER_PAD_EN
            else exp_w.push_back(w);
`endif
        end
    endfunction

    // mode 0: ready held high (or low for 'stall' cycles after first valid); mode 1: random ready.
    task automatic do_drain(input int mode, input int stall, input int restart_at);
        int sc;
        int cyc;
        bit restarted;
        sc = 0;
        cyc = 0;
        restarted = 1'b0;
        foreach (src[i]) fq.push_back(src[i]);
        got.delete();
        pop_cnt = 0;
        done_cnt = 0;
        seen_valid = 1'b0;
        out_ready_i = (stall == 0);
        @(posedge rclock); #1;
        drain_start_i = 1'b1;
        @(posedge rclock); #1;
        drain_start_i = 1'b0;
        while (done_cnt == 0 && cyc < 3000) begin
            if (mode == 1) begin
                out_ready_i = ($urandom_range(0, 9) < 7);
            end else if (stall > 0 && seen_valid) begin
                if (sc >= stall) out_ready_i = 1'b1;
                else sc++;
            end
            if (restart_at >= 0 && !restarted && pop_cnt >= restart_at) begin
                drain_start_i = 1'b1;
                restarted = 1'b1;
            end else begin
                drain_start_i = 1'b0;
            end
            @(posedge rclock); #1;
            cyc++;
        end
        drain_start_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge rclock);
        #1;
    endtask

    task automatic compare_result(input string tag, input int exp_cnt);
        check({tag, "_nwords"}, 32'(got.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            check({tag, "_word"}, got[i], exp_w[i]);
        end
        check({tag, "_pops"}, 32'(pop_cnt), 32'(src.size()));
        check({tag, "_drained_cnt"}, 32'(drained_cnt_o), 32'(exp_cnt));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    typedef struct {
        int          n;
        int          base;
        int          stall;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
        int          cnt;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{8, 1, 0, 1, 32'h87654321, 32'h0, 8};
        vt[1] = '{16, 0, 10, 2, 32'h76543210, 32'hFEDCBA98, 16};
`ifdef FIFO_FLUSH_READER_PAD_EN
        vt[2] = '{3, 10, 0, 1, 32'h00000CBA, 32'h0, 3};
`else
        vt[2] = '{3, 10, 0, 0, 32'h0, 32'h0, 3};
`endif
        vt[3] = '{0, 0, 0, 0, 32'h0, 32'h0, 0};

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge rclock);
        #1;
        check("rst_pop", 32'(fifo_pop_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", out_data_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_cnt", 32'(drained_cnt_o), 32'd0);
        reset = 1'b0;
        @(posedge rclock); #1;

        // Empty FIFO: DRAIN for one cycle, done_o in the following (DONE) cycle.
        drain_start_i = 1'b1;
        @(posedge rclock); #1;
        drain_start_i = 1'b0;
        check("empty_c1_busy", 32'(busy_o), 32'd1);
        check("empty_c1_done", 32'(done_o), 32'd0);
        check("empty_c1_pop", 32'(fifo_pop_o), 32'd0);
        @(posedge rclock); #1;
        check("empty_c2_done", 32'(done_o), 32'd1);
        check("empty_c2_pop", 32'(fifo_pop_o), 32'd0);
        @(posedge rclock); #1;
        check("empty_c3_done", 32'(done_o), 32'd0);
        check("empty_c3_busy", 32'(busy_o), 32'd0);
        check("empty_cnt", 32'(drained_cnt_o), 32'd0);

        // Table vectors
        for (int v = 0; v < 4; v++) begin
            src.delete();
            for (int i = 0; i < vt[v].n; i++) src.push_back(4'((vt[v].base + i) & 15));
            exp_w.delete();
            if (vt[v].nwords > 0) exp_w.push_back(vt[v].w0);
            if (vt[v].nwords > 1) exp_w.push_back(vt[v].w1);
            do_drain(0, vt[v].stall, -1);
            compare_result($sformatf("vec%0d", v), vt[v].cnt);
        end

        // Repeated start during DRAIN must not restart or clear the count.
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(4'((i * 3) & 15));
        build_expected();
        do_drain(0, 0, 3);
        compare_result("restart", 16);

        // Reset mid-drain after five pops.
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(4'((i + 5) & 15));
        foreach (src[i]) fq.push_back(src[i]);
        got.delete();
        pop_cnt = 0;
        done_cnt = 0;
        out_ready_i = 1'b1;
        @(posedge rclock); #1;
        drain_start_i = 1'b1;
        @(posedge rclock); #1;
        drain_start_i = 1'b0;
        for (int c = 0; c < 100 && pop_cnt < 5; c++) begin
            @(posedge rclock); #1;
        end
        check("mid_pops_reached", 32'(pop_cnt >= 5), 32'd1);
        reset = 1'b1;
        @(posedge rclock); #1;
        check("mid_rst_pop", 32'(fifo_pop_o), 32'd0);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_data", out_data_o, 32'h0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_cnt", 32'(drained_cnt_o), 32'd0);
        reset = 1'b0;
        fq.delete();
        repeat (5) @(posedge rclock);
        #1;
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_no_word", 32'(got.size()), 32'd0);
        check("mid_idle", 32'(busy_o), 32'd0);

        // Randomized drains with random backpressure; first one saturates the counter.
        for (int it = 0; it < 6; it++) begin
            int n;
            n = (it == 0) ? 70 : int'($urandom_range(0, 40));
            src.delete();
            for (int i = 0; i < n; i++) src.push_back(4'($urandom_range(0, 15)));
            build_expected();
            do_drain(1, 0, -1);
            compare_result($sformatf("rand%0d", it), (n > 63) ? 63 : n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual still running, required finished");
        $fatal(1, "timeout");
    end

endmodule
